ultrasound_ranger: RTL

//  Parametrised ultrasonic range finder: drives a complementary N-pulse burst, blanks ringdown,

---
 rtl/ultrasound_pkg.sv | 36 +++
 rtl/us_burst_gen.sv | 57 +++++
 rtl/ultrasound_ranger.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ultrasound_pkg.sv
`default_nettype none
// ============================================================================
//  Module : ultrasound_pkg
//  Brief  : Shared state encoding, default constants and counter-width helper
//           for the ultrasonic range finder.
//  Rev    : 1.0  initial release
// ============================================================================
package ultrasound_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BURST   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LISTEN  = 3'd3,
    ST_DONE    = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_t;

  // Defaults for a 100 MHz system clock and a 40 kHz transducer
  localparam int c_def_half_period_cyc = 1250;
  localparam int c_def_n_pulses        = 8;
  localparam int c_def_blank_cyc       = 20000;
  localparam int c_def_cyc_per_mm      = 583;
  localparam int c_def_timeout_mm      = 4000;
  localparam int c_def_holdoff_cyc     = 6000000;
  localparam int c_def_echo_min        = 4;
  localparam int c_def_dist_w          = 14;

  // Bits needed for a counter that walks 0..n-1 (never narrower than 1)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : ultrasound_pkg
`default_nettype wire

// File: rtl/us_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module : us_burst_gen
//  Brief  : Complementary N-period transmit burst generator. While en is high
//           it drives tx_p high for the first half-period, then alternates;
//           done flags the final cycle of the last half-period.
//  Rev    : 1.0  initial release
// ============================================================================
module us_burst_gen
  import ultrasound_pkg::*;
#(
  parameter int HALF_PERIOD_CYC = c_def_half_period_cyc,
  parameter int N_PULSES        = c_def_n_pulses
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tx_p,
  output logic tx_n,
  output logic done
);

  localparam int HW = cnt_w(HALF_PERIOD_CYC);
  localparam int NW = cnt_w(2 * N_PULSES);

  localparam logic [HW-1:0] c_half_last = HW'(HALF_PERIOD_CYC - 1);
  localparam logic [NW-1:0] c_hp_last   = NW'(2 * N_PULSES - 1);

  logic [HW-1:0] r_half_cnt;
  logic [NW-1:0] r_hp_cnt;
  logic          r_phase;
  logic          w_half_wrap;

  assign w_half_wrap = (r_half_cnt == c_half_last);

  // Half-period timer and phase; held cleared whenever the burst is not enabled
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_half_cnt <= '0;
      r_hp_cnt   <= '0;
      r_phase    <= 1'b0;
    end else if (w_half_wrap) begin
      r_half_cnt <= '0;
      r_phase    <= ~r_phase;
      r_hp_cnt   <= r_hp_cnt + 1'b1;
    end else begin
      r_half_cnt <= r_half_cnt + 1'b1;
    end
  end

  // Drive is gated by en so both phases are off outside the burst
  assign tx_p = en & ~r_phase;
  assign tx_n = en &  r_phase;
  assign done = en & w_half_wrap & (r_hp_cnt == c_hp_last);

endmodule : us_burst_gen
`default_nettype wire

// File: rtl/ultrasound_ranger.sv
`default_nettype none
// ============================================================================
//  Module : ultrasound_ranger
//  Brief  : Ultrasonic range finder. Fires a transmit burst, blanks ringdown,
//           times the filtered echo and reports distance in mm. Single-shot
//           on a start button edge or free-running in continuous mode.
//  Rev    : 1.0  initial release
// ============================================================================
module ultrasound_ranger
  import ultrasound_pkg::*;
#(
  parameter int HALF_PERIOD_CYC = c_def_half_period_cyc,
  parameter int N_PULSES        = c_def_n_pulses,
  parameter int BLANK_CYC       = c_def_blank_cyc,
  parameter int CYC_PER_MM      = c_def_cyc_per_mm,
  parameter int TIMEOUT_MM      = c_def_timeout_mm,
  parameter int HOLDOFF_CYC     = c_def_holdoff_cyc,
  parameter int ECHO_MIN        = c_def_echo_min,
  parameter int DIST_W          = c_def_dist_w
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              echo,
  output logic              tx_p,
  output logic              tx_n,
  output logic              busy,
  output logic [DIST_W-1:0] distance_mm,
  output logic              valid,
  output logic              timeout
);

  localparam int PW = cnt_w(CYC_PER_MM);
  localparam int BW = cnt_w(BLANK_CYC);
  localparam int HW = cnt_w(HOLDOFF_CYC);
  localparam int EW = cnt_w(ECHO_MIN + 1);

  localparam logic [PW-1:0]     c_presc_last   = PW'(CYC_PER_MM - 1);
  localparam logic [BW-1:0]     c_blank_last   = BW'(BLANK_CYC - 1);
  localparam logic [HW-1:0]     c_hold_last    = HW'(HOLDOFF_CYC - 1);
  localparam logic [EW-1:0]     c_echo_min     = EW'(ECHO_MIN);
  localparam logic [EW-1:0]     c_echo_min_m1  = EW'(ECHO_MIN - 1);
  localparam logic [DIST_W-1:0] c_timeout      = DIST_W'(TIMEOUT_MM);
  localparam logic [DIST_W-1:0] c_range_max    = {DIST_W{1'b1}};

  state_t            r_state;
  logic              r_busy;
  logic              r_valid;
  logic              r_timeout;
  logic [DIST_W-1:0] r_distance_mm;
  logic [BW-1:0]     r_blank_cnt;
  logic [HW-1:0]     r_hold_cnt;

  logic              r_start_s1;
  logic              r_start_s2;
  logic              r_start_d;
  logic              w_start_rise;

  logic              r_echo_s1;
  logic              r_echo_s2;
  logic [EW-1:0]     r_echo_cnt;
  logic              r_echo_q;
  logic [EW-1:0]     w_echo_cnt_nxt;
  logic              w_echo_q_nxt;
  logic              w_echo_rise;

  logic [PW-1:0]     r_presc;
  logic [DIST_W-1:0] r_range;
  logic [PW-1:0]     w_presc_nxt;
  logic [DIST_W-1:0] w_range_nxt;
  logic              w_counting;

  logic              w_burst_en;
  logic              w_burst_done;

  // Transmit burst generator, enabled for exactly the BURST state
  assign w_burst_en = (r_state == ST_BURST);

  us_burst_gen #(
    .HALF_PERIOD_CYC (HALF_PERIOD_CYC),
    .N_PULSES        (N_PULSES)
  ) u_burst_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_burst_en),
    .tx_p  (tx_p),
    .tx_n  (tx_n),
    .done  (w_burst_done)
  );

  // Two-flop synchronisers for the async button and echo comparator, plus start edge history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
      r_echo_s1  <= 1'b0;
      r_echo_s2  <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_echo_s1  <= echo;
      r_echo_s2  <= r_echo_s1;
    end
  end

  assign w_start_rise = r_start_s2 & ~r_start_d;

  // Echo qualifier: the sample that completes ECHO_MIN consecutive highs raises echo_q
  always_comb begin
    w_echo_cnt_nxt = '0;
    w_echo_q_nxt   = 1'b0;
    if (r_echo_s2) begin
      w_echo_cnt_nxt = (r_echo_cnt == c_echo_min) ? r_echo_cnt : r_echo_cnt + 1'b1;
      w_echo_q_nxt   = (r_echo_cnt >= c_echo_min_m1);
    end
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_echo_cnt <= '0;
      r_echo_q   <= 1'b0;
    end else begin
      r_echo_cnt <= w_echo_cnt_nxt;
      r_echo_q   <= w_echo_q_nxt;
    end
  end

  // A rise is acted on at the edge that sets echo_q, so valid lines up with echo_q
  assign w_echo_rise = w_echo_q_nxt & ~r_echo_q;

  assign w_counting = (r_state == ST_BURST) || (r_state == ST_BLANK) ||
                      (r_state == ST_LISTEN);

  // Next prescaler/range values: zero while idle so the first BURST cycle is cycle 0
  always_comb begin
    w_presc_nxt = '0;
    w_range_nxt = '0;
    if (w_counting) begin
      w_range_nxt = r_range;
      if (r_presc == c_presc_last) begin
        w_presc_nxt = '0;
        if (r_range != c_range_max) begin
          w_range_nxt = r_range + 1'b1;
        end
      end else begin
        w_presc_nxt = r_presc + 1'b1;
      end
    end
  end

  // Prescaler and saturating range counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_range <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      r_range <= w_range_nxt;
    end
  end

  // Measurement sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_timeout     <= 1'b0;
      r_distance_mm <= '0;
      r_blank_cnt   <= '0;
      r_hold_cnt    <= '0;
    end else begin
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_blank_cnt <= '0;
      r_hold_cnt  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise || continuous) begin
            r_state <= ST_BURST;
            r_busy  <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_burst_done) begin
            r_state <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (r_blank_cnt == c_blank_last) begin
            r_state <= ST_LISTEN;
          end else begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
          end
        end
        ST_LISTEN: begin
          // Echo takes priority over a simultaneous window expiry
          if (w_echo_rise) begin
            r_distance_mm <= w_range_nxt;
            r_valid       <= 1'b1;
            r_state       <= ST_DONE;
          end else if (w_range_nxt >= c_timeout) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (continuous) begin
            r_state <= ST_HOLDOFF;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (!continuous) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_hold_cnt == c_hold_last) begin
            r_state <= ST_BURST;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign timeout     = r_timeout;
  assign distance_mm = r_distance_mm;

endmodule : ultrasound_ranger
`default_nettype wire
